// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter feeding a single UART transmitter through a one-entry output buffer.
// Optional round-robin tie-break when UART_ARB_RR_EN is defined; fixed priority (req0 wins) otherwise.
module uart_tx_arbiter #(
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic [1:0]        grant,
    output logic              busy
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              tx_valid_reg;
    logic [DATA_W-1:0] tx_data_reg;
    logic              arm_reg;
    logic              can_load;
    logic              xfer0, xfer1, xfer, xfer_last;
    logic [DATA_W-1:0] xfer_data;
    logic              pick1;

    // Buffer can take a new byte when empty or being drained this same cycle.
    assign can_load   = !tx_valid_reg || tx_ready;
    assign req0_ready = (state_reg == GNT0) && can_load;
    assign req1_ready = (state_reg == GNT1) && can_load;
    assign xfer0      = req0_valid && req0_ready;
    assign xfer1      = req1_valid && req1_ready;
    assign xfer       = xfer0 || xfer1;
    assign xfer_last  = xfer0 ? req0_last : req1_last;
    assign xfer_data  = xfer0 ? req0_data : req1_data;

    assign grant    = {state_reg == GNT1, state_reg == GNT0};
    assign busy     = (state_reg != IDLE) || tx_valid_reg;
    assign tx_valid = tx_valid_reg;
    assign tx_data  = tx_data_reg;

`ifdef UART_ARB_RR_EN
    logic last_owner_reg, last_owner_next;

    // On a tie the requester that did not own the last grant wins.
    assign pick1 = req1_valid && (!req0_valid || !last_owner_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner_reg <= 1'b1;
        end else begin
            last_owner_reg <= last_owner_next;
        end
    end

    always_comb begin
        last_owner_next = last_owner_reg;
        if (state_reg == IDLE && arm_reg && (req0_valid || req1_valid)) begin
            last_owner_next = pick1;
        end
    end
`else
    assign pick1 = req1_valid && !req0_valid;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (arm_reg && (req0_valid || req1_valid)) begin
                    state_next = pick1 ? GNT1 : GNT0;
                end
            end
            GNT0, GNT1: begin
                if (xfer) begin
                    if (xfer_last || cnt_reg == CNT_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // arm_reg holds off the first grant until one full clock after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
            arm_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            arm_reg   <= 1'b1;
            if (xfer) begin
                tx_valid_reg <= 1'b1;
                tx_data_reg  <= xfer_data;
            end else if (tx_ready) begin
                tx_valid_reg <= 1'b0;
            end
        end
    end
endmodule
